servo_slew: RTL

- Rate limiter between the command state machine's per-servo position registers and the PWM servo driver.
- Accepts an 8-bit target position and ramps its 8-bit output toward it by a fixed step on each prescaled tick.
- Holds a settle dwell at the target, then reports completion, so the controller sequences moves without hammering the dispense/sort mechanics.
- One instance per servo.

---
 rtl/servo_slew.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/servo_slew.sv
// Slew-rate limiter for one servo: ramps pos_out toward the latched target by STEP per tick, then dwells.
// Optional macro SERVO_SLEW_CLAMP_EN clamps the effective target to [MIN_POS, MAX_POS].
module servo_slew #(
  parameter int          CLK_DIV      = 50000,
  parameter int          STEP         = 4,
  parameter int          SETTLE_TICKS = 20,
  parameter logic [7:0]  HOME_POS     = 8'h88,
  parameter logic [7:0]  MIN_POS      = 8'h10,
  parameter logic [7:0]  MAX_POS      = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tgt_pos,
  input  logic       tgt_valid,
  output logic [7:0] pos_out,
  output logic       busy,
  output logic       done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int SW = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
  localparam logic [PW-1:0] DIV_LAST    = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_TICKS);
  localparam logic [8:0]    STEP9       = 9'(STEP);
  localparam logic [7:0]    STEP8       = 8'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] div_cnt;
  logic          tick;
  logic [7:0]    pos_q, pos_d;
  logic [7:0]    target_q;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [7:0]    raw_tgt;
  logic [7:0]    eff;
  logic [8:0]    diff;
  logic [8:0]    mag;
  logic [7:0]    step_pos;

  // Free-running prescaler; a new target never resynchronises it.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick    = (div_cnt == DIV_LAST);
  assign raw_tgt = tgt_valid ? tgt_pos : target_q;

`ifdef SERVO_SLEW_CLAMP_EN
  always_comb begin
    eff = raw_tgt;
    if (raw_tgt < MIN_POS) begin
      eff = MIN_POS;
    end else if (raw_tgt > MAX_POS) begin
      eff = MAX_POS;
    end
  end
`else
  logic unused_clamp_bounds;
  assign unused_clamp_bounds = ^{MIN_POS, MAX_POS};
  assign eff = raw_tgt;
`endif

  // Signed 9-bit distance; a full stride is only taken when it cannot overshoot, so no wrap is possible.
  always_comb begin
    diff = {1'b0, eff} - {1'b0, pos_q};
    mag  = diff[8] ? (9'd0 - diff) : diff;
    if (mag <= STEP9) begin
      step_pos = eff;
    end else if (diff[8]) begin
      step_pos = pos_q - STEP8;
    end else begin
      step_pos = pos_q + STEP8;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          if (eff != pos_q) begin
            state_d = RAMP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RAMP: begin
        if (tick) begin
          pos_d = step_pos;
          if (step_pos == eff) begin
            cnt_d = '0;
            if (SETTLE_TICKS == 0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = SETTLE;
            end
          end
        end
      end
      SETTLE: begin
        if (tgt_valid && (eff != pos_q)) begin
          state_d = RAMP;
          cnt_d   = '0;
        end else if (tgt_valid) begin
          cnt_d = '0;
        end else if (tick) begin
          if ((cnt_q + 1'b1) == SETTLE_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pos_q    <= HOME_POS;
      target_q <= HOME_POS;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      target_q <= eff;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign pos_out = pos_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule
